// File: rtl/nios_dbg_ocimem_arbiter.sv
// ---------------------------------------------------------------------------
// nios_dbg_ocimem_arbiter
//
// Shares the single-port on-chip debug (OCI monitor) RAM between the JTAG
// debug slave (sysclk strobes) and the CPU's Avalon debug-memory slave port.
//
// JTAG side: each strobe is decoded into one pending slot (op, addr, data).
//   take_action_ocimem_a    : load mon_addr from jdo[24:17], clear the error
//                             flag, optionally queue a READ (jdo[35]).
//   take_action_ocimem_b    : queue a WRITE of jdo[34:3] at mon_addr.
//   take_no_action_ocimem_a : queue a READ at mon_addr (streaming read).
// A strobe that arrives while the slot is still occupied is dropped and sets
// the sticky monitor_error flag.
//
// CPU side: plain Avalon slave with waitrequest. Writes finish in the grant
// cycle; reads finish one cycle later, when the RAM data comes back.
//
// Ports:
//   clk, reset_n            clock, asynchronous active-low reset
//   jdo, take_*             debug-slave data register and strobes
//   cpu_*                   Avalon debug-memory slave
//   ram_*                   single-port RAM (read data one cycle after ram_re)
//   MonDReg                 JTAG read-data register
//   monitor_ready           high when no JTAG operation is outstanding
//   monitor_error           sticky JTAG overrun flag
// ---------------------------------------------------------------------------
module nios_dbg_ocimem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic [DATA_W-1:0] cpu_writedata,
    output logic [DATA_W-1:0] cpu_readdata,
    output logic              cpu_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_re,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic [DATA_W-1:0] MonDReg,
    output logic              monitor_ready,
    output logic              monitor_error
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_JRD  = 2'b01,
        ST_CRD  = 2'b10
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    state_t            state_r;
    state_t            state_nxt_s;

    // Held low while reset is asserted and for the first edge after release,
    // so a CPU request held across reset cannot reach the RAM combinationally.
    logic              active_r;

    logic              jtag_pend_r;
    logic              pend_write_r;
    logic [ADDR_W-1:0] pend_addr_r;
    logic [DATA_W-1:0] pend_data_r;
    logic [ADDR_W-1:0] mon_addr_r;
    logic [DATA_W-1:0] mon_dreg_r;
    logic              monitor_ready_r;
    logic              monitor_error_r;
    logic              last_grant_jtag_r;

    logic              strobe_s;
    logic              new_op_s;
    logic              new_write_s;
    logic [ADDR_W-1:0] new_addr_s;
    logic [DATA_W-1:0] new_data_s;
    logic              accept_s;
    logic              overrun_s;
    logic              cpu_req_s;
    logic              grant_jtag_s;
    logic              grant_cpu_s;
    logic              jtag_done_s;

    // jdo bits that carry no meaning for the memory commands
    logic              unused_jdo_s;
    assign unused_jdo_s = ^{jdo[37:36], jdo[2:0]};

    // JTAG strobe decode; simultaneous strobes resolve a > b > no_action
    always_comb begin
        strobe_s    = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
        new_op_s    = 1'b0;
        new_write_s = 1'b0;
        new_addr_s  = mon_addr_r;
        new_data_s  = {DATA_W{1'b0}};
        if (take_action_ocimem_a) begin
            new_op_s   = jdo[35];
            new_addr_s = jdo[17 +: ADDR_W];
        end else if (take_action_ocimem_b) begin
            new_op_s    = 1'b1;
            new_write_s = 1'b1;
            new_data_s  = jdo[3 +: DATA_W];
        end else if (take_no_action_ocimem_a) begin
            new_op_s = 1'b1;
        end else begin
            new_op_s = 1'b0;
        end
        accept_s  = new_op_s & ~jtag_pend_r;
        overrun_s = strobe_s & jtag_pend_r;
    end

    // Arbitration: only in IDLE; on contention grant the side that did not win last
    always_comb begin
        cpu_req_s    = cpu_read | cpu_write;
        grant_jtag_s = 1'b0;
        grant_cpu_s  = 1'b0;
        if ((state_r == ST_IDLE) && active_r) begin
            if (jtag_pend_r && cpu_req_s) begin
                if (last_grant_jtag_r) begin
                    grant_cpu_s = 1'b1;
                end else begin
                    grant_jtag_s = 1'b1;
                end
            end else if (jtag_pend_r) begin
                grant_jtag_s = 1'b1;
            end else if (cpu_req_s) begin
                grant_cpu_s = 1'b1;
            end else begin
                grant_jtag_s = 1'b0;
            end
        end else begin
            grant_jtag_s = 1'b0;
        end
        // A JTAG write retires in its grant cycle, a JTAG read in JRD
        jtag_done_s = (grant_jtag_s & pend_write_r) | (state_r == ST_JRD);
    end

    // RAM and Avalon outputs; address/data driven to zero when the RAM is idle
    always_comb begin
        ram_we          = 1'b0;
        ram_re          = 1'b0;
        ram_addr        = {ADDR_W{1'b0}};
        ram_wdata       = {DATA_W{1'b0}};
        cpu_waitrequest = 1'b1;
        cpu_readdata    = {DATA_W{1'b0}};
        if (grant_jtag_s) begin
            ram_addr = pend_addr_r;
            if (pend_write_r) begin
                ram_we    = 1'b1;
                ram_wdata = pend_data_r;
            end else begin
                ram_re = 1'b1;
            end
        end else if (grant_cpu_s) begin
            ram_addr = cpu_address;
            if (cpu_write) begin
                ram_we          = 1'b1;
                ram_wdata       = cpu_writedata;
                cpu_waitrequest = 1'b0;
            end else begin
                ram_re = 1'b1;
            end
        end else if (state_r == ST_CRD) begin
            cpu_readdata    = ram_rdata;
            cpu_waitrequest = 1'b0;
        end else begin
            cpu_waitrequest = 1'b1;
        end
    end

    // Next-state logic: reads take a second cycle for the RAM data to return
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (grant_jtag_s && !pend_write_r) begin
                    state_nxt_s = ST_JRD;
                end else if (grant_cpu_s && !cpu_write) begin
                    state_nxt_s = ST_CRD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_JRD:  state_nxt_s = ST_IDLE;
            ST_CRD:  state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // State register and post-reset enable
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            active_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            active_r <= 1'b1;
        end
    end

    // Pending JTAG slot: filled on an accepted strobe, emptied on completion
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            jtag_pend_r  <= 1'b0;
            pend_write_r <= 1'b0;
            pend_addr_r  <= {ADDR_W{1'b0}};
            pend_data_r  <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            jtag_pend_r  <= 1'b1;
            pend_write_r <= new_write_s;
            pend_addr_r  <= new_addr_s;
            pend_data_r  <= new_data_s;
        end else if (jtag_done_s) begin
            jtag_pend_r <= 1'b0;
        end else begin
            jtag_pend_r <= jtag_pend_r;
        end
    end

    // Monitor address, read-data register and status flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mon_addr_r      <= {ADDR_W{1'b0}};
            mon_dreg_r      <= {DATA_W{1'b0}};
            monitor_ready_r <= 1'b1;
            monitor_error_r <= 1'b0;
        end else begin
            // An explicit address load wins over the post-access increment
            if (take_action_ocimem_a) begin
                mon_addr_r <= jdo[17 +: ADDR_W];
            end else if (jtag_done_s) begin
                mon_addr_r <= mon_addr_r + ADDR_ONE;
            end else begin
                mon_addr_r <= mon_addr_r;
            end
            if (state_r == ST_JRD) begin
                mon_dreg_r <= ram_rdata;
            end else begin
                mon_dreg_r <= mon_dreg_r;
            end
            if (accept_s) begin
                monitor_ready_r <= 1'b0;
            end else if (jtag_done_s) begin
                monitor_ready_r <= 1'b1;
            end else begin
                monitor_ready_r <= monitor_ready_r;
            end
            if (overrun_s) begin
                monitor_error_r <= 1'b1;
            end else if (take_action_ocimem_a) begin
                monitor_error_r <= 1'b0;
            end else begin
                monitor_error_r <= monitor_error_r;
            end
        end
    end

    // Remember who won the last grant for round-robin fairness
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_jtag_r <= 1'b0;
        end else if (grant_jtag_s) begin
            last_grant_jtag_r <= 1'b1;
        end else if (grant_cpu_s) begin
            last_grant_jtag_r <= 1'b0;
        end else begin
            last_grant_jtag_r <= last_grant_jtag_r;
        end
    end

    assign MonDReg       = mon_dreg_r;
    assign monitor_ready = monitor_ready_r;
    assign monitor_error = monitor_error_r;

endmodule

// File: tb/tb_nios_dbg_ocimem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_nios_dbg_ocimem_arbiter
//
// Self-checking bench: a cycle-by-cycle vector table for JTAG write/read,
// streaming read and CPU write/read, followed by hand-written sequences for
// address wrap, contention ordering, overrun and reset in the middle of a CPU
// read. The RAM is a behavioural model here; its initial contents are
// mem[i] = 0x1000_0000 | i, except mem[0xFF] = 0xA5 and mem[0x00] = 0x5A.
// ---------------------------------------------------------------------------
module tb_nios_dbg_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a;
    logic        take_action_ocimem_b;
    logic        take_no_action_ocimem_a;
    logic        cpu_read;
    logic        cpu_write;
    logic [7:0]  cpu_address;
    logic [31:0] cpu_writedata;
    logic [31:0] cpu_readdata;
    logic        cpu_waitrequest;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic        ram_we;
    logic        ram_re;
    logic [31:0] ram_rdata;
    logic [31:0] MonDReg;
    logic        monitor_ready;
    logic        monitor_error;

    int checks = 0;
    int errors = 0;

    nios_dbg_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
        .clk                     (clk),
        .reset_n                 (reset_n),
        .jdo                     (jdo),
        .take_action_ocimem_a    (take_action_ocimem_a),
        .take_action_ocimem_b    (take_action_ocimem_b),
        .take_no_action_ocimem_a (take_no_action_ocimem_a),
        .cpu_read                (cpu_read),
        .cpu_write               (cpu_write),
        .cpu_address             (cpu_address),
        .cpu_writedata           (cpu_writedata),
        .cpu_readdata            (cpu_readdata),
        .cpu_waitrequest         (cpu_waitrequest),
        .ram_addr                (ram_addr),
        .ram_wdata               (ram_wdata),
        .ram_we                  (ram_we),
        .ram_re                  (ram_re),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .monitor_ready           (monitor_ready),
        .monitor_error           (monitor_error)
    );

    always #5 clk = ~clk;

    // Behavioural single-port RAM, loaded with a known pattern on the first edge
    logic [31:0] mem [256];
    logic        mem_loaded = 1'b0;
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= 32'h1000_0000 | 32'(i);
            mem[8'hFF] <= 32'h0000_00A5;
            mem[8'h00] <= 32'h0000_005A;
            mem_loaded <= 1'b1;
        end else begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            if (ram_re) ram_rdata <= mem[ram_addr];
        end
    end

    typedef struct {
        logic [2:0]  stb;     // {a, b, no_action}
        logic        jrd;
        logic [7:0]  jaddr;
        logic [31:0] jdata;
        logic [1:0]  cop;     // {write, read}
        logic [7:0]  caddr;
        logic [31:0] cwd;
        logic        we;
        logic        re;
        logic [7:0]  ra;
        logic [31:0] rwd;
        logic        wt;
        logic [31:0] crd;
        logic        rdy;
        logic        err;
        logic [31:0] mon;
    } vec_t;

    localparam int NV = 15;
    vec_t vecs [NV];

    function automatic vec_t mk(
        input logic [2:0] stb, input logic jrd, input logic [7:0] jaddr, input logic [31:0] jdata,
        input logic [1:0] cop, input logic [7:0] caddr, input logic [31:0] cwd,
        input logic we, input logic re, input logic [7:0] ra, input logic [31:0] rwd,
        input logic wt, input logic [31:0] crd, input logic rdy, input logic err, input logic [31:0] mon);
        vec_t v;
        v.stb = stb; v.jrd = jrd; v.jaddr = jaddr; v.jdata = jdata;
        v.cop = cop; v.caddr = caddr; v.cwd = cwd;
        v.we = we; v.re = re; v.ra = ra; v.rwd = rwd; v.wt = wt;
        v.crd = crd; v.rdy = rdy; v.err = err; v.mon = mon;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [2:0] stb, input logic jrd, input logic [7:0] jaddr,
                         input logic [31:0] jdata, input logic [1:0] cop,
                         input logic [7:0] caddr, input logic [31:0] cwd);
        take_action_ocimem_a    = stb[2];
        take_action_ocimem_b    = stb[1];
        take_no_action_ocimem_a = stb[0];
        jdo = stb[2] ? {2'b00, jrd, 10'b0, jaddr, 17'b0} : {3'b000, jdata, 3'b000};
        cpu_write     = cop[1];
        cpu_read      = cop[0];
        cpu_address   = caddr;
        cpu_writedata = cwd;
    endtask

    task automatic idle();
        drive(3'b000, 1'b0, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0);
    endtask

    // Move to 1 ns after the next rising edge; checks happen 2 ns later
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input string name);
        int n = 0;
        while (!monitor_ready && n < 20) begin
            cyc();
            #2;
            n++;
        end
        chk({name, " ready timeout"}, 32'(monitor_ready), 32'h1);
    endtask

    initial begin
        int re_count;
        int n;

        // Vector table: one row per clock cycle
        vecs[0]  = mk(3'b100, 1'b0, 8'h10, 32'h0,         2'b00, 8'h00, 32'h0,         1'b0, 1'b0, 8'h00, 32'h0,         1'b1, 32'h0,         1'b1, 1'b0, 32'h0);
        vecs[1]  = mk(3'b010, 1'b0, 8'h00, 32'hDEADBEEF,  2'b00, 8'h00, 32'h0,         1'b0, 1'b0, 8'h00, 32'h0,         1'b1, 32'h0,         1'b1, 1'b0, 32'h0);
        vecs[2]  = mk(3'b000, 1'b0, 8'h00, 32'h0,         2'b00, 8'h00, 32'h0,         1'b1, 1'b0, 8'h10, 32'hDEADBEEF,  1'b1, 32'h0,         1'b0, 1'b0, 32'h0);
        vecs[3]  = mk(3'b100, 1'b1, 8'h10, 32'h0,         2'b00, 8'h00, 32'h0,         1'b0, 1'b0, 8'h00, 32'h0,         1'b1, 32'h0,         1'b1, 1'b0, 32'h0);
        vecs[4]  = mk(3'b000, 1'b0, 8'h00, 32'h0,         2'b00, 8'h00, 32'h0,         1'b0, 1'b1, 8'h10, 32'h0,         1'b1, 32'h0,         1'b0, 1'b0, 32'h0);
        vecs[5]  = mk(3'b000, 1'b0, 8'h00, 32'h0,         2'b00, 8'h00, 32'h0,         1'b0, 1'b0, 8'h00, 32'h0,         1'b1, 32'h0,         1'b0, 1'b0, 32'h0);
        vecs[6]  = mk(3'b000, 1'b0, 8'h00, 32'h0,         2'b00, 8'h00, 32'h0,         1'b0, 1'b0, 8'h00, 32'h0,         1'b1, 32'h0,         1'b1, 1'b0, 32'hDEADBEEF);
        vecs[7]  = mk(3'b001, 1'b0, 8'h00, 32'h0,         2'b00, 8'h00, 32'h0,         1'b0, 1'b0, 8'h00, 32'h0,         1'b1, 32'h0,         1'b1, 1'b0, 32'hDEADBEEF);
        vecs[8]  = mk(3'b000, 1'b0, 8'h00, 32'h0,         2'b00, 8'h00, 32'h0,         1'b0, 1'b1, 8'h11, 32'h0,         1'b1, 32'h0,         1'b0, 1'b0, 32'hDEADBEEF);
        vecs[9]  = mk(3'b000, 1'b0, 8'h00, 32'h0,         2'b00, 8'h00, 32'h0,         1'b0, 1'b0, 8'h00, 32'h0,         1'b1, 32'h0,         1'b0, 1'b0, 32'hDEADBEEF);
        vecs[10] = mk(3'b000, 1'b0, 8'h00, 32'h0,         2'b00, 8'h00, 32'h0,         1'b0, 1'b0, 8'h00, 32'h0,         1'b1, 32'h0,         1'b1, 1'b0, 32'h10000011);
        vecs[11] = mk(3'b000, 1'b0, 8'h00, 32'h0,         2'b10, 8'h03, 32'h12345678,  1'b1, 1'b0, 8'h03, 32'h12345678,  1'b0, 32'h0,         1'b1, 1'b0, 32'h10000011);
        vecs[12] = mk(3'b000, 1'b0, 8'h00, 32'h0,         2'b01, 8'h03, 32'h0,         1'b0, 1'b1, 8'h03, 32'h0,         1'b1, 32'h0,         1'b1, 1'b0, 32'h10000011);
        vecs[13] = mk(3'b000, 1'b0, 8'h00, 32'h0,         2'b01, 8'h03, 32'h0,         1'b0, 1'b0, 8'h00, 32'h0,         1'b0, 32'h12345678,  1'b1, 1'b0, 32'h10000011);
        vecs[14] = mk(3'b000, 1'b0, 8'h00, 32'h0,         2'b00, 8'h00, 32'h0,         1'b0, 1'b0, 8'h00, 32'h0,         1'b1, 32'h0,         1'b1, 1'b0, 32'h10000011);

        // Reset with a CPU read held: nothing may reach the RAM
        reset_n = 1'b0;
        idle();
        drive(3'b000, 1'b0, 8'h00, 32'h0, 2'b01, 8'h07, 32'h0);
        repeat (3) cyc();
        #2;
        chk("rst ram_re",        32'(ram_re),          32'h0);
        chk("rst ram_we",        32'(ram_we),          32'h0);
        chk("rst waitrequest",   32'(cpu_waitrequest), 32'h1);
        chk("rst readdata",      cpu_readdata,         32'h0);
        chk("rst MonDReg",       MonDReg,              32'h0);
        chk("rst monitor_ready", 32'(monitor_ready),   32'h1);
        chk("rst monitor_error", 32'(monitor_error),   32'h0);
        idle();
        @(negedge clk);
        reset_n = 1'b1;

        // Table-driven section
        for (int i = 0; i < NV; i++) begin
            cyc();
            drive(vecs[i].stb, vecs[i].jrd, vecs[i].jaddr, vecs[i].jdata,
                  vecs[i].cop, vecs[i].caddr, vecs[i].cwd);
            #2;
            chk($sformatf("v%0d ram_we", i),       32'(ram_we),          32'(vecs[i].we));
            chk($sformatf("v%0d ram_re", i),       32'(ram_re),          32'(vecs[i].re));
            chk($sformatf("v%0d ram_addr", i),     32'(ram_addr),        32'(vecs[i].ra));
            chk($sformatf("v%0d ram_wdata", i),    ram_wdata,            vecs[i].rwd);
            chk($sformatf("v%0d waitrequest", i),  32'(cpu_waitrequest), 32'(vecs[i].wt));
            chk($sformatf("v%0d readdata", i),     cpu_readdata,         vecs[i].crd);
            chk($sformatf("v%0d ready", i),        32'(monitor_ready),   32'(vecs[i].rdy));
            chk($sformatf("v%0d error", i),        32'(monitor_error),   32'(vecs[i].err));
            chk($sformatf("v%0d MonDReg", i),      MonDReg,              vecs[i].mon);
        end
        cyc();
        idle();

        // Streaming read across the 0xFF -> 0x00 wrap
        cyc(); drive(3'b100, 1'b0, 8'hFF, 32'h0, 2'b00, 8'h00, 32'h0);
        cyc(); idle();
        cyc(); drive(3'b001, 1'b0, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0);
        cyc(); idle(); #2;
        chk("wrap rd1 ram_re",   32'(ram_re),   32'h1);
        chk("wrap rd1 ram_addr", 32'(ram_addr), 32'hFF);
        wait_ready("wrap rd1");
        chk("wrap rd1 MonDReg", MonDReg, 32'h0000_00A5);
        cyc(); drive(3'b001, 1'b0, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0);
        cyc(); idle(); #2;
        chk("wrap rd2 ram_addr", 32'(ram_addr), 32'h00);
        wait_ready("wrap rd2");
        chk("wrap rd2 MonDReg", MonDReg, 32'h0000_005A);
        cyc(); drive(3'b001, 1'b0, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0);
        cyc(); idle(); #2;
        chk("wrap rd3 ram_re",   32'(ram_re),   32'h1);
        chk("wrap rd3 ram_addr", 32'(ram_addr), 32'h01);
        wait_ready("wrap rd3");
        chk("wrap rd3 MonDReg", MonDReg, 32'h1000_0001);

        // Contention, last grant JTAG: CPU read goes first, then JTAG write at 0x02
        cyc(); drive(3'b010, 1'b0, 8'h00, 32'hCAFEF00D, 2'b00, 8'h00, 32'h0);
        cyc(); drive(3'b000, 1'b0, 8'h00, 32'h0, 2'b01, 8'h20, 32'h0); #2;
        chk("cont1 cpu ram_re",   32'(ram_re),   32'h1);
        chk("cont1 cpu ram_addr", 32'(ram_addr), 32'h20);
        chk("cont1 cpu ram_we",   32'(ram_we),   32'h0);
        cyc(); #2;
        chk("cont1 waitrequest",  32'(cpu_waitrequest), 32'h0);
        chk("cont1 readdata",     cpu_readdata,         32'h1000_0020);
        chk("cont1 crd ram_we",   32'(ram_we),          32'h0);
        cyc(); idle(); #2;
        chk("cont1 jtag ram_we",    32'(ram_we),   32'h1);
        chk("cont1 jtag ram_addr",  32'(ram_addr), 32'h02);
        chk("cont1 jtag ram_wdata", ram_wdata,     32'hCAFEF00D);

        // Contention, last grant CPU: JTAG write at 0x03 goes first, then CPU read
        cyc(); drive(3'b000, 1'b0, 8'h00, 32'h0, 2'b10, 8'h30, 32'h0000_0077); #2;
        chk("cont2 cpu wr ram_we", 32'(ram_we),          32'h1);
        chk("cont2 cpu wr wait",   32'(cpu_waitrequest), 32'h0);
        cyc(); drive(3'b010, 1'b0, 8'h00, 32'h0BADF00D, 2'b00, 8'h00, 32'h0);
        cyc(); drive(3'b000, 1'b0, 8'h00, 32'h0, 2'b01, 8'h20, 32'h0); #2;
        chk("cont2 jtag ram_we",   32'(ram_we),          32'h1);
        chk("cont2 jtag ram_addr", 32'(ram_addr),        32'h03);
        chk("cont2 jtag wdata",    ram_wdata,            32'h0BADF00D);
        chk("cont2 jtag wait",     32'(cpu_waitrequest), 32'h1);
        cyc(); #2;
        chk("cont2 cpu ram_re",   32'(ram_re),          32'h1);
        chk("cont2 cpu ram_addr", 32'(ram_addr),        32'h20);
        cyc(); #2;
        chk("cont2 waitrequest",  32'(cpu_waitrequest), 32'h0);
        chk("cont2 readdata",     cpu_readdata,         32'h1000_0020);
        cyc(); idle();

        // Overrun: back-to-back streaming strobes while the CPU writes nonstop
        re_count = 0;
        cyc(); drive(3'b001, 1'b0, 8'h00, 32'h0, 2'b10, 8'h40, 32'h55); #2;
        if (ram_re) re_count++;
        cyc(); drive(3'b001, 1'b0, 8'h00, 32'h0, 2'b10, 8'h40, 32'h55); #2;
        if (ram_re) re_count++;
        for (int i = 0; i < 8; i++) begin
            cyc(); drive(3'b000, 1'b0, 8'h00, 32'h0, 2'b10, 8'h40, 32'h55); #2;
            if (ram_re) re_count++;
        end
        chk("overrun read count", 32'(re_count), 32'h1);
        cyc(); idle(); #2;
        chk("overrun error set", 32'(monitor_error), 32'h1);
        wait_ready("overrun");
        chk("overrun MonDReg", MonDReg, 32'h1000_0004);
        cyc(); drive(3'b100, 1'b0, 8'h00, 32'h0, 2'b00, 8'h00, 32'h0);
        cyc(); idle(); #2;
        chk("overrun error clear", 32'(monitor_error), 32'h0);

        // Reset in the middle of a CPU read, then a clean read afterwards
        cyc(); drive(3'b000, 1'b0, 8'h00, 32'h0, 2'b01, 8'h05, 32'h0); #2;
        chk("rstcrd grant ram_re", 32'(ram_re), 32'h1);
        cyc(); #2;
        chk("rstcrd in CRD wait", 32'(cpu_waitrequest), 32'h0);
        reset_n = 1'b0;
        #1;
        chk("rstcrd waitrequest", 32'(cpu_waitrequest), 32'h1);
        chk("rstcrd ram_we",      32'(ram_we),          32'h0);
        chk("rstcrd ram_re",      32'(ram_re),          32'h0);
        chk("rstcrd MonDReg",     MonDReg,              32'h0);
        chk("rstcrd ready",       32'(monitor_ready),   32'h1);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        n = 0;
        cyc(); #2;
        while (cpu_waitrequest && n < 10) begin
            cyc(); #2;
            n++;
        end
        chk("post-reset read done", 32'(cpu_waitrequest), 32'h0);
        chk("post-reset readdata",  cpu_readdata,         32'h1000_0005);
        cyc(); idle();
        cyc();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
